// File: rtl/mem_pkg.sv
// Shared types and defaults for the register-file access controller.
// Included ahead of every file that imports mem_pkg.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 8;

endpackage

// File: rtl/lat_counter.sv
// Access latency down-counter: loaded with LAT-1 on entry to WRITE/READ, last at zero.
// Latency: last reflects the registered count; no backpressure.
module lat_counter #(
  parameter int CNT_W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             last
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign last = (cnt == '0);

endmodule

// File: rtl/mem_access_fsm.sv
// Register-file access controller: one access in flight, WR_LAT/RD_LAT strobes, then a valid pulse.
// Latency: LAT+1 cycles per access (1 for an out-of-range address); ready low while an access runs.
module mem_access_fsm
  import mem_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int WR_LAT = 1,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sel,
  input  logic              op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic              ready,
  output logic              valid,
  output logic              rw,
  output logic              err,
  output logic [WIDTH-1:0]  rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  output logic              mem_we,
  output logic              mem_oe,
  input  logic [WIDTH-1:0]  mem_rdata
);

  localparam int MAX_LAT = (WR_LAT > RD_LAT) ? WR_LAT : RD_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  state_t           state;
  logic             accept;
  logic             addr_bad;
  logic             lat_load;
  logic             lat_last;
  logic [CNT_W-1:0] lat_val;

  assign accept   = sel & ready;
  // DEPTH need not be a power of two, so in-range is a real compare.
  assign addr_bad = (32'(addr) >= DEPTH);
  assign lat_load = accept & ~addr_bad;
  assign lat_val  = (op == OP_WRITE) ? CNT_W'(WR_LAT - 1) : CNT_W'(RD_LAT - 1);

  lat_counter #(
    .CNT_W(CNT_W)
  ) u_lat_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (lat_load),
    .load_val (lat_val),
    .last     (lat_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ready     <= 1'b1;
      valid     <= 1'b0;
      rw        <= 1'b0;
      err       <= 1'b0;
      mem_we    <= 1'b0;
      mem_oe    <= 1'b0;
      rdata     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      valid <= 1'b0;
      rw    <= 1'b0;
      err   <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (accept) begin
            if (addr_bad) begin
              // Out-of-range: complete immediately without touching the array.
              state <= DONE;
              valid <= 1'b1;
              err   <= 1'b1;
              rw    <= op;
            end else begin
              mem_addr  <= addr;
              mem_wdata <= wdata;
              ready     <= 1'b0;
              if (op == OP_WRITE) begin
                state  <= WRITE;
                mem_we <= 1'b1;
              end else begin
                state  <= READ;
                mem_oe <= 1'b1;
              end
            end
          end else begin
            state <= IDLE;
          end
        end
        WRITE: begin
          if (lat_last) begin
            state  <= DONE;
            mem_we <= 1'b0;
            ready  <= 1'b1;
            valid  <= 1'b1;
            rw     <= OP_WRITE;
          end
        end
        READ: begin
          if (lat_last) begin
            state  <= DONE;
            mem_oe <= 1'b0;
            ready  <= 1'b1;
            valid  <= 1'b1;
            rw     <= OP_READ;
            rdata  <= mem_rdata;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_fsm.sv
// Randomised bench for mem_access_fsm against a slot-timeline reference model.
module tb_mem_access_fsm;

  localparam int WIDTH  = 8;
  localparam int DEPTH  = 10;
  localparam int ADDR_W = 4;
  localparam int WR_LAT = 2;
  localparam int RD_LAT = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              sel = 1'b0;
  logic              op = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [WIDTH-1:0]  wdata = '0;
  logic [WIDTH-1:0]  mem_rdata = '0;
  logic              ready, valid, rw, err, mem_we, mem_oe;
  logic [WIDTH-1:0]  rdata, mem_wdata;
  logic [ADDR_W-1:0] mem_addr;

  mem_access_fsm #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .WR_LAT(WR_LAT), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sel(sel), .op(op), .addr(addr), .wdata(wdata),
    .ready(ready), .valid(valid), .rw(rw), .err(err), .rdata(rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_oe(mem_oe),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // slot n = the interval following the n-th rising edge
  int slot = 0;
  always @(posedge clk) slot <= slot + 1;

  int n_chk = 0;
  int n_fail = 0;
  int n_acc = 0;
  int n_valid = 0;
  int n_abort = 0;

  // Reference timeline of the single access in flight
  int               free_at, we_lo, we_hi, oe_lo, oe_hi, valid_at, cap_slot, rdata_at;
  logic             exp_rw, exp_err;
  logic [WIDTH-1:0] exp_rdata, cap_val, exp_wdata;
  logic [ADDR_W-1:0] exp_addr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (slot %0d)", tag, got, exp, slot);
    end
  endtask

  task automatic model_reset();
    free_at   = slot;
    we_lo     = -100; we_hi = -100;
    oe_lo     = -100; oe_hi = -100;
    valid_at  = -100;
    cap_slot  = -100;
    rdata_at  = -100;
    exp_rw    = 1'b0; exp_err = 1'b0;
    exp_rdata = '0;
    cap_val   = '0;
  endtask

  // Called just after a falling edge: checks the current slot, then drives the next request.
  task automatic step(input logic s, input logic o, input logic [ADDR_W-1:0] a,
                      input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] rd);
    logic in_we, in_oe, in_valid;
    int k;
    in_we    = (slot >= we_lo) && (slot <= we_hi);
    in_oe    = (slot >= oe_lo) && (slot <= oe_hi);
    in_valid = (slot == valid_at);
    if (slot == rdata_at) exp_rdata = cap_val;
    chk("ready", ready, slot >= free_at);
    chk("mem_we", mem_we, in_we);
    chk("mem_oe", mem_oe, in_oe);
    chk("valid", valid, in_valid);
    chk("rw", rw, in_valid ? exp_rw : 1'b0);
    chk("err", err, in_valid ? exp_err : 1'b0);
    chk("rdata", rdata, exp_rdata);
    chk("we_oe_excl", mem_we & mem_oe, 1'b0);
    if (in_we || in_oe) chk("mem_addr", mem_addr, exp_addr);
    if (in_we) chk("mem_wdata", mem_wdata, exp_wdata);
    if (valid === 1'b1) n_valid++;

    sel = s; op = o; addr = a; wdata = d; mem_rdata = rd;
    if (slot == cap_slot) cap_val = rd;
    if (s && slot >= free_at) begin
      k = slot + 1;
      n_acc++;
      if (int'(a) >= DEPTH) begin
        valid_at = k; free_at = k; exp_rw = o; exp_err = 1'b1;
      end else if (o) begin
        we_lo = k; we_hi = k + WR_LAT - 1; valid_at = k + WR_LAT; free_at = valid_at;
        exp_rw = 1'b1; exp_err = 1'b0; exp_addr = a; exp_wdata = d;
      end else begin
        oe_lo = k; oe_hi = k + RD_LAT - 1; valid_at = k + RD_LAT; free_at = valid_at;
        cap_slot = k + RD_LAT - 1; rdata_at = k + RD_LAT;
        exp_rw = 1'b0; exp_err = 1'b0; exp_addr = a;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, WIDTH'($urandom));
  endtask

  initial begin
    int base;
    repeat (2) @(negedge clk);
    chk("rst_ready", ready, 1'b1);
    chk("rst_valid", valid, 1'b0);
    chk("rst_rw", rw, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_we", mem_we, 1'b0);
    chk("rst_oe", mem_oe, 1'b0);
    chk("rst_rdata", rdata, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    rst_n = 1'b1;
    model_reset();

    // Write 0xA5 to 3, read 3 returning 0x5C, write that must not disturb rdata
    step(1'b1, 1'b1, 4'd3, 8'hA5, 8'h00);
    idle(4);
    for (int i = 0; i < 5; i++) step(i == 0, 1'b0, 4'd3, 8'h00, 8'h5C);
    idle(1);
    step(1'b1, 1'b1, 4'd7, 8'h3C, 8'h11);
    idle(4);
    // Out-of-range read, plus a back-to-back pair of errored requests
    step(1'b1, 1'b0, 4'd12, 8'h00, 8'h99);
    idle(2);
    step(1'b1, 1'b1, 4'd15, 8'h42, 8'h00);
    step(1'b1, 1'b0, 4'd10, 8'h00, 8'h00);
    idle(2);
    // sel held high with alternating op: chains through DONE, busy-cycle sel ignored
    for (int i = 0; i < 16; i++) step(1'b1, i[2], 4'(i % DEPTH), 8'(i * 17), 8'(i * 29 + 3));
    idle(5);

    // Reset dropped in the second WRITE cycle aborts the access
    step(1'b1, 1'b1, 4'd5, 8'h77, 8'h00);
    step(1'b0, 1'b0, '0, '0, '0);
    chk("we_before_rst", mem_we, (slot >= we_lo) && (slot <= we_hi));
    rst_n = 1'b0;
    #1;
    chk("abort_we", mem_we, 1'b0);
    chk("abort_oe", mem_oe, 1'b0);
    chk("abort_ready", ready, 1'b1);
    chk("abort_valid", valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    n_abort++;
    model_reset();
    idle(4);

    // Random traffic: at least 1000 accepted requests, some out of range
    base = n_acc;
    for (int i = 0; i < 20000 && (n_acc - base) < 1000; i++)
      step($urandom_range(0, 3) != 0, 1'($urandom), 4'($urandom_range(0, 15)),
           WIDTH'($urandom), WIDTH'($urandom));
    chk("rand_reqs_done", (n_acc - base) >= 1000, 1'b1);
    idle(6);
    chk("one_valid_per_req", n_valid, n_acc - n_abort);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_fsm.md
# mem_access_fsm

Parametrised access controller for the WIDTH x DEPTH register-file memory and its tri-state data buffer. Generalises the 8x8 `op`/`sel` → `valid`/`rw` controller:
- programmable read and write latencies;
- address range checking;
- a ready/valid handshake;
- a read-data holding register;
- separate write-enable and output-enable strobes for the memory and buffer.

It sits between the requesting logic and the memory array.

## Interface
Parameters:
- WIDTH, 8, data word width in bits
- DEPTH, 8, number of words; need not be a power of two
- ADDR_W, $clog2(DEPTH) (minimum 1), address width
- WR_LAT, 1, cycles `mem_we` is held per write (≥1)
- RD_LAT, 1, cycles `mem_oe` is held per read (≥1)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- sel  in  1  request strobe
- op  in  1  1 = write, 0 = read
- addr  in  ADDR_W  request address
- wdata  in  WIDTH  write data
- ready  out  1  controller can accept a request this cycle
- valid  out  1  one-cycle completion pulse
- rw  out  1  operation type of the completing access (1 = write)
- err  out  1  completing access had addr ≥ DEPTH; qualified by `valid`
- rdata  out  WIDTH  last successful read data, held
- mem_addr  out  ADDR_W  address to the array
- mem_wdata  out  WIDTH  data to the array
- mem_we  out  1  array write enable
- mem_oe  out  1  tri-state buffer output enable
- mem_rdata  in  WIDTH  data from the array/buffer

## Operation
- States: IDLE, WRITE, READ, DONE.
- `ready` = 1 in IDLE and DONE, 0 otherwise.
- A request is accepted on a rising edge with `sel` & `ready`. On acceptance, `op`, `addr` and `wdata` are registered. `sel` while `ready` = 0 is ignored and is not queued.
- Transitions on acceptance:
  - `addr` ≥ DEPTH → DONE with `err` = 1. No `mem_we`/`mem_oe` strobe is issued.
  - otherwise `op` = 1 → WRITE; `op` = 0 → READ.
- WRITE:
  - `mem_we` = 1; `mem_addr`/`mem_wdata` driven from the registers.
  - Stays WRITE_LAT cycles, then → DONE.
- READ:
  - `mem_oe` = 1; `mem_addr` driven.
  - Stays RD_LAT cycles. `rdata` ← `mem_rdata` on the edge leaving READ, then → DONE.
- DONE:
  - `valid` = 1 for exactly one cycle; `rw` and `err` reflect the access.
  - → WRITE/READ/DONE if a new request is accepted, else → IDLE.
- `mem_we` and `mem_oe` are never high together. Both are 0 outside WRITE/READ.
- `rdata` changes only on a successful read; errored reads and all writes leave it unchanged.
- `rw` and `err` are 0 whenever `valid` = 0.
- `mem_addr`/`mem_wdata` hold their last values when idle.

## Timing
- Reset values:
  - state IDLE; `ready` = 1.
  - `valid`, `rw`, `err`, `mem_we`, `mem_oe` = 0.
  - `rdata`, `mem_addr`, `mem_wdata` = 0.
- Write accepted at edge k: `mem_we` high in cycles k+1 .. k+WR_LAT; `valid` high in cycle k+WR_LAT+1.
- Read accepted at edge k: `mem_oe` high in cycles k+1 .. k+RD_LAT; `rdata` updated at edge k+RD_LAT; `valid` high in cycle k+RD_LAT+1.
- Errored request accepted at edge k: `valid` = `err` = 1 in cycle k+1.
- Back-to-back: a request accepted in DONE starts with no IDLE bubble. Peak throughput is one access per LAT+1 cycles.
- `rst_n` low mid-access: `mem_we`/`mem_oe` drop immediately (asynchronously). The access is aborted, and no `valid` is produced after reset is released.
- All outputs are registered or decoded from the state register only. There is no combinational path from `sel`/`op`/`addr` to any output.

## Structure
- Shared package `mem_pkg`:
  - state enum (IDLE/WRITE/READ/DONE);
  - OP_READ/OP_WRITE constants;
  - default WIDTH/DEPTH.
- Sub-module `lat_counter`:
  - down-counter loaded with WR_LAT-1 or RD_LAT-1 on entry to WRITE/READ;
  - asserts `last` at zero.
- The FSM, request registers and `rdata` register stay in `mem_access_fsm`.

## Test plan
- WR_LAT = 2: write addr 3, data 0xA5 → `mem_we` high 2 cycles with `mem_addr` = 3 and `mem_wdata` = 0xA5. Next cycle `valid` = 1, `rw` = 1, `err` = 0.
- RD_LAT = 3, `mem_rdata` = 0x5C: read addr 3 → `mem_oe` high 3 cycles, `mem_we` never high. Then `valid` = 1, `rw` = 0, `rdata` = 0x5C, held across a following write.
- DEPTH = 10: read addr 12 → next cycle `valid` = `err` = 1. No strobes; `rdata` unchanged.
- `sel` held high with alternating `op` → accesses chain through DONE with no IDLE cycle. `sel` during WRITE/READ is ignored; exactly one `valid` per accepted request.
- Drop `rst_n` in the second WRITE cycle → `mem_we` = 0 immediately. After release, `ready` = 1 and no `valid` pulse.
- Check `mem_we` & `mem_oe` never both high, and `valid` never high two consecutive cycles for a single request, over 1000 random requests.
